// File: rtl/pipe_sub_pkg.sv
// Shared types and helpers for the pipelined ripple-borrow subtractor.
// stage_t is sized for the widest supported operand. Each instance uses only
// the low WIDTH bits, and synthesis trims the rest.
package pipe_sub_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Payload carried by each pipeline stage.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] a_rem;      // minuend; upper chunks are still unresolved
    logic [MAX_WIDTH-1:0] b_rem;      // subtrahend; upper chunks are still unresolved
    logic [MAX_WIDTH-1:0] diff;       // difference chunks resolved so far
    logic                 borrow;     // borrow out of the last resolved chunk
    logic                 approx_en;
    logic                 clamp_neg;
    logic                 valid;
  } stage_t;

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    return width / chunk;
  endfunction

  // LSB position of chunk k.
  function automatic int unsigned chunk_lsb(input int unsigned k,
                                            input int unsigned chunk);
    return k * chunk;
  endfunction

endpackage

// File: rtl/pipe_borrow_sub_chunk.sv
// sub_chunk: combinational CHUNK-bit ripple-borrow subtract slice.
// Ports: x/y   - operand chunks (x - y)
//        mask  - bits set here use no borrow-in (approximate bits)
//        bin   - borrow into bit 0
//        diff  - difference chunk
//        bout  - borrow out of the top bit
// A masked bit gives x^y. Its borrow-out is only the generate term ~x&y, so
// the first unmasked bit above a masked run sees the borrow of the top
// masked bit.
module sub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic [CHUNK-1:0] mask,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic brw;

  // Ripple the borrow from LSB to MSB.
  always_comb begin
    brw  = bin;
    diff = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (mask[i]) begin
        diff[i] = x[i] ^ y[i];
        brw     = ~x[i] & y[i];
      end else begin
        diff[i] = x[i] ^ y[i] ^ brw;
        brw     = (~(x[i] ^ y[i]) & brw) | (~x[i] & y[i]);
      end
    end
    bout = brw;
  end

endmodule

// File: rtl/pipe_borrow_sub.sv
// pipe_borrow_sub: pipelined ripple-borrow subtractor, diff = a - b.
// It resolves CHUNK bits per stage. An output register then applies the
// negative clamp. A beat accepted at edge N is visible after edge N+STAGES.
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready   - input handshake; in_ready = ~out_valid | out_ready
//        a, b                - operands
//        approx_en           - low APPROX_BITS bits computed borrow-free
//        clamp_neg           - a negative result outputs diff = 0
//        out_valid/out_ready - output handshake
//        diff, borrow_out    - result and final borrow (borrow is never clamped)
module pipe_borrow_sub
  import pipe_sub_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CHUNK       = 4,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  input  logic             clamp_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);
  localparam logic [CHUNK-1:0] AMASK = {CHUNK{1'b1}} >> (CHUNK - APPROX_BITS);

  // Elaboration-time parameter checks.
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $fatal(1, "pipe_borrow_sub: WIDTH must be a multiple of CHUNK");
  end
  if (APPROX_BITS < 1 || APPROX_BITS > CHUNK) begin : g_bad_approx
    $fatal(1, "pipe_borrow_sub: APPROX_BITS must be in 1..CHUNK");
  end
  if (WIDTH > MAX_WIDTH) begin : g_too_wide
    $fatal(1, "pipe_borrow_sub: WIDTH exceeds MAX_WIDTH");
  end

  logic en;

  // A single global enable stalls every stage together, so the pipeline
  // never drops or duplicates a beat.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LSB = chunk_lsb(k, CHUNK);

    stage_t           pin;
    stage_t           nxt;
    stage_t           q;
    logic [CHUNK-1:0] mask;
    logic [CHUNK-1:0] dchunk;
    logic             bout;

    if (k == 0) begin : g_first
      // Pack the incoming beat. Stage 0 has no borrow-in.
      always_comb begin
        pin           = '0;
        pin.a_rem     = MAX_WIDTH'(a);
        pin.b_rem     = MAX_WIDTH'(b);
        pin.approx_en = approx_en;
        pin.clamp_neg = clamp_neg;
        pin.valid     = in_valid;
      end
      assign mask = pin.approx_en ? AMASK : '0;
    end else begin : g_rest
      assign pin  = g_stage[k-1].q;
      assign mask = '0;
    end

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x   (pin.a_rem[LSB +: CHUNK]),
      .y   (pin.b_rem[LSB +: CHUNK]),
      .mask(mask),
      .bin (pin.borrow),
      .diff(dchunk),
      .bout(bout)
    );

    // Forward the payload, inserting this stage's chunk and borrow.
    always_comb begin
      nxt                     = pin;
      nxt.diff[LSB +: CHUNK]  = dchunk;
      nxt.borrow              = bout;
    end

    // Stage register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (en) begin
        q <= nxt;
      end
    end
  end

  stage_t last;
  logic   unused_last;

  assign last        = g_stage[STAGES-1].q;
  assign unused_last = ^last;

  // Output register. Applies the clamp; the borrow is reported unmasked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (en) begin
      out_valid  <= last.valid;
      borrow_out <= last.borrow;
      diff       <= (last.clamp_neg && last.borrow) ? '0 : WIDTH'(last.diff);
    end
  end

endmodule

// File: tb/tb_pipe_borrow_sub.sv
// Self-checking bench for pipe_borrow_sub (WIDTH=16, CHUNK=4, APPROX_BITS=4).
module tb_pipe_borrow_sub;

  localparam int unsigned STAGES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        approx_en;
  logic        clamp_neg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;

  pipe_borrow_sub #(.WIDTH(16), .CHUNK(4), .APPROX_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .clamp_neg (clamp_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [16:0] v;    // {borrow, diff}
    int unsigned t;    // cyc at the negedge before acceptance
    logic        lat;  // check latency on pop
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ap;
    logic        cl;
    logic [15:0] exp_d;
    logic        exp_b;
  } vec_t;

  sb_t         sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pops     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level reference model. Returns {borrow, diff}.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ap, input logic cl);
    logic [15:0] d;
    logic        bo;
    logic        bin4;
    logic [12:0] up;
    if (ap) begin
      bin4 = ~x[3] & y[3];
      up   = {1'b0, x[15:4]} - {1'b0, y[15:4]} - 13'(bin4);
      d    = {up[11:0], x[3:0] ^ y[3:0]};
      bo   = up[12];
    end else begin
      {bo, d} = {1'b0, x} - {1'b0, y};
    end
    if (cl && bo) d = '0;
    return {bo, d};
  endfunction

  task automatic pop_check();
    sb_t e;
    pops++;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_output: got diff 0x%0h borrow %0b with empty scoreboard",
               diff, borrow_out);
    end else begin
      e = sb.pop_front();
      chk("result", 32'({borrow_out, diff}), 32'(e.v));
      if (e.lat) chk("latency", 32'(cyc - e.t), 32'(STAGES + 1));
    end
  endtask

  // Call right after a negedge. Drives one cycle and scores both handshakes.
  task automatic cyc_drive(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                           input logic iap, input logic icl, input logic ordy,
                           input logic lat_chk, input logic [16:0] expv);
    sb_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    approx_en = iap;
    clamp_neg = icl;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) pop_check();
    if (in_valid && in_ready) begin
      e.v   = expv;
      e.t   = cyc;
      e.lat = lat_chk;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      cyc_drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 17'h0);
    end
  endtask

  vec_t        vecs[12];
  int unsigned sent;
  int unsigned pops0;
  logic        first_seen;
  int unsigned stall_left;
  logic        held;
  logic [16:0] held_v;
  logic        ordy;
  logic        iv;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    vecs[0]  = '{16'h1234, 16'h0235, 1'b0, 1'b0, 16'h0FFF, 1'b0};
    vecs[1]  = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'hFFFF, 1'b1};
    vecs[2]  = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'hFFFF, 1'b1};
    vecs[4]  = '{16'h0010, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0};
    vecs[5]  = '{16'h0010, 16'h0001, 1'b0, 1'b0, 16'h000F, 1'b0};
    vecs[6]  = '{16'h0008, 16'h0008, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{16'h0005, 16'h000A, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    vecs[10] = '{16'h0005, 16'h000A, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[11] = '{16'h0013, 16'h0005, 1'b1, 1'b0, 16'h0016, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    approx_en = 1'b0; clamp_neg = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_diff", 32'(diff), 32'h0);
    chk("reset_borrow", 32'(borrow_out), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back table beats, no stalls: every result at fixed latency.
    foreach (vecs[i]) begin
      @(negedge clk);
      cyc_drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ap, vecs[i].cl, 1'b1, 1'b1,
                {vecs[i].exp_b, vecs[i].exp_d});
    end
    idle(STAGES + 3);
    chk("table_drain", 32'(sb.size()), 32'h0);

    // Backpressure: 6 beats, out_ready low for 5 cycles from the first result.
    sent = 0; pops0 = pops; first_seen = 1'b0; stall_left = 0; held = 1'b0; held_v = '0;
    for (int c = 0; c < 60 && (sent < 6 || sb.size() != 0); c++) begin
      @(negedge clk);
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall_left = 5;
      end
      ordy = (stall_left == 0);
      if (stall_left != 0) stall_left--;
      if (held) chk("hold_result", 32'({borrow_out, diff}), 32'(held_v));
      ra = 16'(16'h1111 * sent + 16'h0042);
      rb = 16'(16'h0203 * sent + 16'h0321);
      cyc_drive(sent < 6, ra, rb, 1'b0, 1'b0, ordy, 1'b0, model(ra, rb, 1'b0, 1'b0));
      if (in_valid && in_ready) sent++;
      if (!ordy) chk("in_ready_stall", 32'(in_ready), 32'h0);
      held   = out_valid && !ordy;
      held_v = {borrow_out, diff};
    end
    in_valid = 1'b0;
    chk("bp_results", 32'(pops - pops0), 32'd6);
    chk("bp_drain", 32'(sb.size()), 32'h0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ra = 16'(16'h0100 + i);
      cyc_drive(i < 5, ra, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, model(ra, 16'h0001, 1'b0, 1'b0));
    end
    @(posedge clk);
    #2;
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'h0);
    chk("async_reset_diff", 32'({borrow_out, diff}), 32'h0);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cyc_drive(1'b1, 16'h00FF, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 16'h00F0});
    pops0 = pops;
    idle(STAGES + 4);
    chk("post_reset_results", 32'(pops - pops0), 32'd1);
    chk("post_reset_drain", 32'(sb.size()), 32'h0);

    // Random exact-mode stream with random bubbles and stalls.
    sent = 0;
    for (int c = 0; c < 40000 && (sent < 10000 || sb.size() != 0); c++) begin
      @(negedge clk);
      iv = (sent < 10000) && ($urandom_range(0, 9) < 8);
      ra = 16'($urandom);
      rb = 16'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      cyc_drive(iv, ra, rb, 1'b0, 1'b0, ordy, 1'b0, model(ra, rb, 1'b0, 1'b0));
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("random_sent", 32'(sent), 32'd10000);
    chk("random_drain", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
